// File: rtl/dmem_stall_ctrl_pkg.sv
// Shared types and constants for the data-memory stall controller.
// FSM state encoding, MMIO register offsets and the default MMIO window base.
package dmem_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic [15:0] MMIO_BASE_DEF = 16'hFF00;

   localparam logic [15:0] LED_OFS = 16'd0;
   localparam logic [15:0] CYC_OFS = 16'd1;
   localparam logic [15:0] STC_OFS = 16'd2;

   function automatic logic [15:0] mmio_offset(input logic [15:0] addr,
                                               input logic [15:0] base);
      return addr - base;
   endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Bus bundle between core memory stage, stall controller and data SRAM.
// The slave modport is the controller; the master modport is the core/SRAM side.
interface dmem_stall_ctrl_if;

   logic        req_valid;
   logic        req_we;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
      output stall, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_rdata,
      input  stall, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dmem_mmio_regs.sv
// MMIO register block: LED register, free-running cycle counter, store counter.
// Read data is combinational from current register state (pre-increment values).
module dmem_mmio_regs
   import dmem_stall_ctrl_pkg::*;
#(
   parameter int unsigned LED_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             store_done,
   input  logic [15:0]      offset,
   input  logic [LED_W-1:0] wdata,
   output logic [31:0]      rd_data,
   output logic [LED_W-1:0] led,
   output logic [31:0]      cycle_cnt
);

   logic [LED_W-1:0] led_q, led_d;
   logic [31:0]      cycle_cnt_q, cycle_cnt_d;
   logic [31:0]      store_cnt_q, store_cnt_d;

   always_comb begin
      led_d       = led_q;
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      store_cnt_d = store_cnt_q;
      if (wr_en && (offset == LED_OFS)) begin
         led_d = wdata;
      end
      if (store_done) begin
         store_cnt_d = store_cnt_q + 32'd1;
      end
   end

   always_comb begin
      rd_data = '0;
      case (offset)
         LED_OFS: rd_data[LED_W-1:0] = led_q;
         CYC_OFS: rd_data = cycle_cnt_q;
         STC_OFS: rd_data = store_cnt_q;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q       <= '0;
         cycle_cnt_q <= '0;
         store_cnt_q <= '0;
      end else begin
         led_q       <= led_d;
         cycle_cnt_q <= cycle_cnt_d;
         store_cnt_q <= store_cnt_d;
      end
   end

   assign led       = led_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Data-memory access controller: stalls the core while a multi-cycle SRAM access
// completes and services a small MMIO window at the top of the word-address space.
module dmem_stall_ctrl
   import dmem_stall_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [15:0] MMIO_BASE   = MMIO_BASE_DEF,
   parameter int unsigned LED_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   dmem_stall_ctrl_if.slave   bus,
   output logic [LED_W-1:0]   led,
   output logic [31:0]        cycle_cnt
);

   localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

   state_e      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        we_q, we_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   logic        is_mmio;
   logic        mmio_wr;
   logic        store_done;
   logic [31:0] mmio_rdata;

   assign is_mmio = (bus.req_addr >= MMIO_BASE);

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      we_d        = we_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      mmio_wr     = 1'b0;
      store_done  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d = bus.req_we;
               if (is_mmio) begin
                  // MMIO completes at this edge; read mux sees pre-increment counters
                  mmio_wr = bus.req_we;
                  if (!bus.req_we) begin
                     rsp_rdata_d = mmio_rdata;
                  end
                  state_d = ST_DONE;
               end else begin
                  mem_en_d    = 1'b1;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = bus.req_addr;
                  mem_wdata_d = bus.req_wdata;
                  wait_cnt_d  = '0;
                  state_d     = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (wait_cnt_q == WS_LAST) begin
               if (!we_q) begin
                  rsp_rdata_d = bus.mem_rdata;
               end
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               state_d  = ST_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            store_done = we_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         we_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         we_q        <= we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.stall     = ((state_q == ST_IDLE) && bus.req_valid) || (state_q == ST_ACCESS);
   assign bus.rsp_valid = (state_q == ST_DONE);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   dmem_mmio_regs #(
      .LED_W(LED_W)
   ) u_regs (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (mmio_wr),
      .store_done (store_done),
      .offset     (mmio_offset(bus.req_addr, MMIO_BASE)),
      .wdata      (bus.req_wdata[LED_W-1:0]),
      .rd_data    (mmio_rdata),
      .led        (led),
      .cycle_cnt  (cycle_cnt)
   );

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl: a vector table run on a WAIT_STATES=2 instance,
// plus hand sequences for reset abort, back-to-back requests, counter wrap and WAIT_STATES=0.
module tb_dmem_stall_ctrl;
   import dmem_stall_ctrl_pkg::*;

   logic clk;
   logic reset;

   dmem_stall_ctrl_if bif2();
   dmem_stall_ctrl_if bif0();

   logic [15:0] led2, led0;
   logic [31:0] cyc2, cyc0;

   dmem_stall_ctrl #(.WAIT_STATES(2), .MMIO_BASE(16'hFF00), .LED_W(16)) dut2 (
      .clk(clk), .reset(reset), .bus(bif2), .led(led2), .cycle_cnt(cyc2)
   );

   dmem_stall_ctrl #(.WAIT_STATES(0), .MMIO_BASE(16'hFF00), .LED_W(16)) dut0 (
      .clk(clk), .reset(reset), .bus(bif0), .led(led0), .cycle_cnt(cyc0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM models: write commits on the last enabled cycle of an access
   logic [31:0] sram2 [256];
   logic [31:0] sram0 [256];
   int          ecnt2 = 0, ecnt0 = 0;
   int          wrs2 = 0, wrs0 = 0;

   assign bif2.mem_rdata = sram2[bif2.mem_addr[7:0]];
   assign bif0.mem_rdata = sram0[bif0.mem_addr[7:0]];

   always @(posedge clk) begin
      if (bif2.mem_en && bif2.mem_we && ecnt2 == 2) begin
         sram2[bif2.mem_addr[7:0]] <= bif2.mem_wdata;
         wrs2 <= wrs2 + 1;
      end
      ecnt2 <= bif2.mem_en ? ecnt2 + 1 : 0;
   end

   always @(posedge clk) begin
      if (bif0.mem_en && bif0.mem_we && ecnt0 == 0) begin
         sram0[bif0.mem_addr[7:0]] <= bif0.mem_wdata;
         wrs0 <= wrs0 + 1;
      end
      ecnt0 <= bif0.mem_en ? ecnt0 + 1 : 0;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Called at a negedge; returns at the negedge after the response pulse.
   task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                         output int stalls, output int pulses, output logic [31:0] rd);
      stalls = 0;
      pulses = 0;
      bif2.req_valid = 1'b1;
      bif2.req_we    = we;
      bif2.req_addr  = a;
      bif2.req_wdata = d;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bif2.stall) stalls++;
         if (bif2.rsp_valid) pulses++;
         @(negedge clk);
         if (pulses != 0) break;
      end
      bif2.req_valid = 1'b0;
      rd = bif2.rsp_rdata;
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          stalls;
      logic [31:0] rdata;
      logic [15:0] led;
      int          wrs;
   } vec_t;

   vec_t vt[12];

   initial begin
      int          st, pu, b2b_st, b2b_pu;
      int          en_n, we_n;
      logic [31:0] rd, c0, seen_addr, seen_wdata;
      logic [9:0]  pmask;

      for (int i = 0; i < 256; i++) begin
         sram2[i] = '0;
         sram0[i] = '0;
      end
      sram2[8'h04] = 32'h12345678;
      sram2[8'h10] = 32'h11111111;

      vt[0]  = '{1'b0, 16'h0004, 32'h0,        4, 32'h12345678, 16'h0000, 0};
      vt[1]  = '{1'b1, 16'hFF00, 32'h0001BEEF, 1, 32'h12345678, 16'hBEEF, 0};
      vt[2]  = '{1'b0, 16'hFF00, 32'h0,        1, 32'h0000BEEF, 16'hBEEF, 0};
      vt[3]  = '{1'b0, 16'hFF02, 32'h0,        1, 32'h00000001, 16'hBEEF, 0};
      vt[4]  = '{1'b0, 16'hFF05, 32'h0,        1, 32'h00000000, 16'hBEEF, 0};
      vt[5]  = '{1'b1, 16'h0030, 32'h00000055, 4, 32'h00000000, 16'hBEEF, 1};
      vt[6]  = '{1'b0, 16'h0030, 32'h0,        4, 32'h00000055, 16'hBEEF, 1};
      vt[7]  = '{1'b0, 16'hFF02, 32'h0,        1, 32'h00000002, 16'hBEEF, 1};
      vt[8]  = '{1'b1, 16'hFF01, 32'h0,        1, 32'h00000002, 16'hBEEF, 1};
      vt[9]  = '{1'b1, 16'hFF03, 32'h0000FFFF, 1, 32'h00000002, 16'hBEEF, 1};
      vt[10] = '{1'b0, 16'hFF00, 32'h0,        1, 32'h0000BEEF, 16'hBEEF, 1};
      vt[11] = '{1'b0, 16'hFF02, 32'h0,        1, 32'h00000004, 16'hBEEF, 1};

      bif2.req_valid = 1'b0; bif2.req_we = 1'b0; bif2.req_addr = '0; bif2.req_wdata = '0;
      bif0.req_valid = 1'b0; bif0.req_we = 1'b0; bif0.req_addr = '0; bif0.req_wdata = '0;

      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_stall",     32'(bif2.stall),     32'h0);
      check("rst_rsp_valid", 32'(bif2.rsp_valid), 32'h0);
      check("rst_mem_en",    32'(bif2.mem_en),    32'h0);
      check("rst_mem_we",    32'(bif2.mem_we),    32'h0);
      check("rst_rsp_rdata", bif2.rsp_rdata,      32'h0);
      check("rst_mem_addr",  32'(bif2.mem_addr),  32'h0);
      check("rst_led",       32'(led2),           32'h0);
      check("rst_cycle_cnt", cyc2,                32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of a RAM store must abort it cleanly
      bif2.req_valid = 1'b1; bif2.req_we = 1'b1;
      bif2.req_addr = 16'h0010; bif2.req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      bif2.req_valid = 1'b0;
      @(negedge clk);
      check("abort_mem_en_before", 32'(bif2.mem_en), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_mem_en",  32'(bif2.mem_en),  32'h0);
      check("abort_stall",   32'(bif2.stall),   32'h0);
      check("abort_state",   32'(dut2.state_q), 32'(ST_IDLE));
      check("abort_led",     32'(led2),         32'h0);
      check("abort_cyc",     cyc2,              32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_sram",     sram2[8'h10], 32'h11111111);
      check("abort_wr_count", 32'(wrs2),    32'h0);
      check("abort_rsp_none", 32'(bif2.rsp_valid), 32'h0);

      for (int i = 0; i < 12; i++) begin
         do_req(vt[i].we, vt[i].addr, vt[i].wdata, st, pu, rd);
         check($sformatf("vec%0d_stalls", i), 32'(st),      32'(vt[i].stalls));
         check($sformatf("vec%0d_pulses", i), 32'(pu),      32'h1);
         check($sformatf("vec%0d_rdata", i),  rd,           vt[i].rdata);
         check($sformatf("vec%0d_led", i),    32'(led2),    32'(vt[i].led));
         check($sformatf("vec%0d_wrs", i),    32'(wrs2),    32'(vt[i].wrs));
      end
      check("ram_store_word", sram2[8'h30], 32'h00000055);

      // Back-to-back: req_valid held through DONE; DONE must not start a request
      bif2.req_valid = 1'b1; bif2.req_we = 1'b0; bif2.req_addr = 16'h0004;
      b2b_st = 0; b2b_pu = 0; pmask = '0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bif2.stall) b2b_st++;
         if (bif2.rsp_valid) begin
            b2b_pu++;
            pmask[c] = 1'b1;
         end
         @(negedge clk);
      end
      bif2.req_valid = 1'b0;
      check("b2b_pulses", 32'(b2b_pu), 32'h2);
      check("b2b_stalls", 32'(b2b_st), 32'h8);
      check("b2b_pmask",  32'(pmask),  32'h210);
      check("b2b_rdata",  bif2.rsp_rdata, 32'h12345678);

      // Cycle counter wrap
      @(negedge clk);
      force dut2.u_regs.cycle_cnt_q = 32'hFFFFFFFE;
      #1;
      release dut2.u_regs.cycle_cnt_q;
      #1;
      check("wrap_start", cyc2, 32'hFFFFFFFE);
      @(posedge clk); #1;
      check("wrap_1", cyc2, 32'hFFFFFFFF);
      @(posedge clk); #1;
      check("wrap_2", cyc2, 32'h00000000);
      @(posedge clk); #1;
      check("wrap_3", cyc2, 32'h00000001);

      @(negedge clk);
      c0 = cyc2;
      do_req(1'b1, 16'hFF01, 32'h0, st, pu, rd);
      check("ro_store_cyc", cyc2, c0 + 32'd2);
      @(negedge clk);
      c0 = cyc2;
      do_req(1'b0, 16'hFF01, 32'h0, st, pu, rd);
      check("cyc_read_pre_inc", rd, c0);

      // WAIT_STATES=0 store on the second instance
      @(negedge clk);
      bif0.req_valid = 1'b1; bif0.req_we = 1'b1;
      bif0.req_addr = 16'h0020; bif0.req_wdata = 32'hA5A5A5A5;
      st = 0; pu = 0; en_n = 0; we_n = 0; seen_addr = '0; seen_wdata = '0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (bif0.stall) st++;
         if (bif0.mem_en) begin
            en_n++;
            seen_addr  = 32'(bif0.mem_addr);
            seen_wdata = bif0.mem_wdata;
         end
         if (bif0.mem_we) we_n++;
         if (bif0.rsp_valid) begin
            pu++;
            bif0.req_valid = 1'b0;
         end
         @(negedge clk);
      end
      bif0.req_valid = 1'b0;
      check("ws0_stalls", 32'(st),   32'h2);
      check("ws0_en",     32'(en_n), 32'h1);
      check("ws0_we",     32'(we_n), 32'h1);
      check("ws0_addr",   seen_addr, 32'h00000020);
      check("ws0_wdata",  seen_wdata, 32'hA5A5A5A5);
      check("ws0_pulses", 32'(pu),   32'h1);
      check("ws0_sram",   sram0[8'h20], 32'hA5A5A5A5);
      check("ws0_wrs",    32'(wrs0), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
